// File: rtl/trng_pkg.sv
// Shared definitions for the TRNG sampler: FSM state encoding and default
// warm-up / repetition-limit values.
package trng_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2,
        ST_FAULT  = 2'd3
    } trng_state_e;

    localparam int unsigned TRNG_WARMUP_CYCLES_DEF = 256;
    localparam int unsigned TRNG_REP_LIMIT_DEF     = 32;

endpackage

// File: rtl/trng_synchronizer.sv
// Multi-flop synchronizer bringing one asynchronous oscillator bit into clk.
module trng_synchronizer #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o
);

    logic [STAGES-1:0] ff_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff_q <= '0;
        end else begin
            ff_q <= {ff_q[STAGES-2:0], async_i};
        end
    end

    assign sync_o = ff_q[STAGES-1];

endmodule

// File: rtl/trng_sampler.sv
// Ring-oscillator TRNG sampler: synchronize, XOR, health-test and pack raw bits
// into words. Define TRNG_VON_NEUMANN_EN to debias RUN bits with a Von Neumann corrector.
module trng_sampler
    import trng_pkg::*;
#(
    parameter int unsigned RO_COUNT      = 4,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned OUT_WIDTH     = 8,
    parameter int unsigned WARMUP_CYCLES = TRNG_WARMUP_CYCLES_DEF,
    parameter int unsigned REP_LIMIT     = TRNG_REP_LIMIT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [RO_COUNT-1:0]  roIn,
    output logic                 roEnable,
    output logic [OUT_WIDTH-1:0] randomData,
    output logic                 randomValid,
    input  logic                 randomReady,
    output logic                 healthFail
);

    // Warm-up also spans the synchronizer flush, so no sample taken before
    // roEnable rose can reach RUN.
    localparam int unsigned WARM_LEN = WARMUP_CYCLES + SYNC_STAGES - 1;
    localparam int unsigned WW = (WARM_LEN > 1) ? $clog2(WARM_LEN) : 1;
    localparam int unsigned RW = $clog2(REP_LIMIT + 1);
    localparam int unsigned CW = $clog2(OUT_WIDTH + 1);

    logic [RO_COUNT-1:0] ro_sync;
    logic                raw_bit;

    for (genvar g = 0; g < RO_COUNT; g++) begin : g_sync
        trng_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
            .clk    (clk),
            .rst    (rst),
            .async_i(roIn[g]),
            .sync_o (ro_sync[g])
        );
    end

    assign raw_bit = ^ro_sync;

    trng_state_e          state_q, state_d;
    logic [WW-1:0]        warm_q, warm_d;
    logic [RW-1:0]        rep_q, rep_d;
    logic                 prev_q, prev_d;
    logic [OUT_WIDTH-1:0] coll_q, coll_d;
    logic [CW-1:0]        ccnt_q, ccnt_d;
    logic [OUT_WIDTH-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 fail_q, fail_d;
    logic                 roen_q, roen_d;
`ifdef TRNG_VON_NEUMANN_EN
    logic                 vn_phase_q, vn_phase_d;
    logic                 vn_first_q, vn_first_d;
`endif

    logic                 free, bit_vld, bit_val, clr;
    logic [RW-1:0]        rep_next;
    logic [OUT_WIDTH-1:0] coll_base, shifted;
    logic [CW-1:0]        cnt_base;

    always_comb begin
        state_d   = state_q;
        warm_d    = warm_q;
        rep_d     = rep_q;
        prev_d    = prev_q;
        coll_d    = coll_q;
        ccnt_d    = ccnt_q;
        data_d    = data_q;
        valid_d   = valid_q & ~randomReady;
        fail_d    = fail_q;
        roen_d    = roen_q;
`ifdef TRNG_VON_NEUMANN_EN
        vn_phase_d = vn_phase_q;
        vn_first_d = vn_first_q;
`endif
        free      = ~valid_q | randomReady;
        bit_vld   = 1'b0;
        bit_val   = 1'b0;
        clr       = 1'b0;
        rep_next  = '0;
        coll_base = coll_q;
        cnt_base  = ccnt_q;
        shifted   = '0;

        unique case (state_q)
            ST_IDLE: begin
                roen_d = 1'b0;
                if (enable) begin
                    state_d = ST_WARMUP;
                    warm_d  = '0;
                    roen_d  = 1'b1;
                end
            end
            ST_WARMUP: begin
                if (!enable) begin
                    clr = 1'b1;
                end else if (warm_q == WW'(WARM_LEN - 1)) begin
                    state_d = ST_RUN;
                    warm_d  = '0;
                end else begin
                    warm_d = warm_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    clr = 1'b1;
                end else begin
                    rep_next = (rep_q != '0 && raw_bit == prev_q) ? rep_q + 1'b1 : RW'(1);
                    rep_d    = rep_next;
                    prev_d   = raw_bit;
                    if (rep_next == RW'(REP_LIMIT)) begin
                        state_d = ST_FAULT;
                        fail_d  = 1'b1;
                        roen_d  = 1'b0;
                        valid_d = 1'b0;
                        coll_d  = '0;
                        ccnt_d  = '0;
`ifdef TRNG_VON_NEUMANN_EN
                        vn_phase_d = 1'b0;
                        vn_first_d = 1'b0;
`endif
                    end else begin
`ifdef TRNG_VON_NEUMANN_EN
                        if (!vn_phase_q) begin
                            vn_phase_d = 1'b1;
                            vn_first_d = raw_bit;
                        end else begin
                            vn_phase_d = 1'b0;
                            bit_vld    = (vn_first_q != raw_bit);
                            bit_val    = vn_first_q;
                        end
`else
                        bit_vld = 1'b1;
                        bit_val = raw_bit;
`endif
                        // A full collector drains first so the incoming bit can start the next word.
                        if (ccnt_q == CW'(OUT_WIDTH) && free) begin
                            data_d    = coll_q;
                            valid_d   = 1'b1;
                            coll_base = '0;
                            cnt_base  = '0;
                        end
                        coll_d = coll_base;
                        ccnt_d = cnt_base;
                        if (bit_vld && cnt_base != CW'(OUT_WIDTH)) begin
                            shifted = {coll_base[OUT_WIDTH-2:0], bit_val};
                            if (cnt_base == CW'(OUT_WIDTH - 1) && free) begin
                                data_d  = shifted;
                                valid_d = 1'b1;
                                coll_d  = '0;
                                ccnt_d  = '0;
                            end else begin
                                coll_d = shifted;
                                ccnt_d = cnt_base + 1'b1;
                            end
                        end
                    end
                end
            end
            ST_FAULT: begin
                roen_d  = 1'b0;
                valid_d = 1'b0;
            end
        endcase

        if (clr) begin
            state_d = ST_IDLE;
            roen_d  = 1'b0;
            warm_d  = '0;
            rep_d   = '0;
            prev_d  = 1'b0;
            coll_d  = '0;
            ccnt_d  = '0;
`ifdef TRNG_VON_NEUMANN_EN
            vn_phase_d = 1'b0;
            vn_first_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            warm_q  <= '0;
            rep_q   <= '0;
            prev_q  <= 1'b0;
            coll_q  <= '0;
            ccnt_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            fail_q  <= 1'b0;
            roen_q  <= 1'b0;
`ifdef TRNG_VON_NEUMANN_EN
            vn_phase_q <= 1'b0;
            vn_first_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            warm_q  <= warm_d;
            rep_q   <= rep_d;
            prev_q  <= prev_d;
            coll_q  <= coll_d;
            ccnt_q  <= ccnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            fail_q  <= fail_d;
            roen_q  <= roen_d;
`ifdef TRNG_VON_NEUMANN_EN
            vn_phase_q <= vn_phase_d;
            vn_first_q <= vn_first_d;
`endif
        end
    end

    assign roEnable    = roen_q;
    assign randomData  = data_q;
    assign randomValid = valid_q;
    assign healthFail  = fail_q;

endmodule

// File: tb/tb_trng_sampler.sv
// Directed self-checking bench for trng_sampler (WARMUP_CYCLES=4, SYNC_STAGES=2).
// Raw bits are forced on roIn[0]; bit j driven at cycle 4+j enters RUN at cycle 7+j.
module tb_trng_sampler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [3:0] ro = '0;
    logic       roEnable;
    logic [7:0] randomData;
    logic       randomValid;
    logic       randomReady = 1'b0;
    logic       healthFail;

    int total = 0;
    int bad   = 0;

    logic [63:0] strm;
    int          slen;
    int          n;
    logic        fill_bit;

    trng_sampler #(
        .RO_COUNT     (4),
        .SYNC_STAGES  (2),
        .OUT_WIDTH    (8),
        .WARMUP_CYCLES(4),
        .REP_LIMIT    (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .roIn       (ro),
        .roEnable   (roEnable),
        .randomData (randomData),
        .randomValid(randomValid),
        .randomReady(randomReady),
        .healthFail (healthFail)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start(input logic [63:0] s, input int len);
        @(negedge clk);
        strm   = s;
        slen   = len;
        n      = 0;
        ro     = '0;
        enable = 1'b1;
    endtask

    task automatic to_cyc(input int k);
        while (n < k) begin
            @(negedge clk);
            n++;
            if (n >= 4 && (n - 4) < slen) ro[0] = strm[slen - 1 - (n - 4)];
            else                          ro[0] = fill_bit;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_roen"},  32'(roEnable),    32'd0);
        chk({tag, "_valid"}, 32'(randomValid), 32'd0);
        chk({tag, "_data"},  32'(randomData),  32'd0);
        chk({tag, "_fail"},  32'(healthFail),  32'd0);
    endtask

`ifdef TRNG_VON_NEUMANN_EN
    localparam logic [63:0] E_STREAM = 64'b01101110000101101001;
    localparam int          E_LEN    = 20;
    localparam int          E_AT     = 27;
    localparam logic [31:0] E_WORD   = 32'h66;
`else
    localparam logic [63:0] E_STREAM = 64'hA5;
    localparam int          E_LEN    = 8;
    localparam int          E_AT     = 16;
    localparam logic [31:0] E_WORD   = 32'hA5;
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        fill_bit = 1'b0;
        n        = 0;
        slen     = 0;
        strm     = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

`ifdef TRNG_VON_NEUMANN_EN
        // Pairs 01,10,11,10,00,01,01,10,10,01 -> bits 0,1,1,0,0,1,1,0
        randomReady = 1'b1;
        start(64'b01101110000101101001, 20);
        to_cyc(25);
        chk("vn_valid_early", 32'(randomValid), 32'd0);
        to_cyc(26);
        chk("vn_valid", 32'(randomValid), 32'd1);
        chk("vn_data",  32'(randomData),  32'h66);
        enable = 1'b0;
        to_cyc(30);
`else
        // Word assembly and minimum latency
        randomReady = 1'b1;
        start(64'hB2, 8);
        to_cyc(1);
        chk("a_roen_warm", 32'(roEnable), 32'd1);
        to_cyc(13);
        chk("a_valid_early", 32'(randomValid), 32'd0);
        to_cyc(14);
        chk("a_valid", 32'(randomValid), 32'd1);
        chk("a_data",  32'(randomData),  32'hB2);
        to_cyc(15);
        chk("a_valid_once", 32'(randomValid), 32'd0);
        enable = 1'b0;
        to_cyc(16);
        chk("a_roen_idle",  32'(roEnable),    32'd0);
        chk("a_valid_idle", 32'(randomValid), 32'd0);
        to_cyc(20);

        // Drop enable with 5 bits collected, then a fresh run
        start(64'h15, 5);
        to_cyc(11);
        enable = 1'b0;
        to_cyc(12);
        chk("b_roen_idle",  32'(roEnable),    32'd0);
        chk("b_valid_idle", 32'(randomValid), 32'd0);
        to_cyc(14);
        start(64'h3C, 8);
        to_cyc(6);
        chk("b_roen_warm",  32'(roEnable),    32'd1);
        chk("b_valid_warm", 32'(randomValid), 32'd0);
        to_cyc(13);
        chk("b_valid_early", 32'(randomValid), 32'd0);
        to_cyc(14);
        chk("b_valid", 32'(randomValid), 32'd1);
        chk("b_data",  32'(randomData),  32'h3C);
        to_cyc(15);
        enable = 1'b0;
        to_cyc(18);

        // Back-pressure: word1 held, word2 parked, word3 dropped
        randomReady = 1'b0;
        start(64'hA569C355, 32);
        to_cyc(14);
        chk("c_valid_w1", 32'(randomValid), 32'd1);
        chk("c_data_w1",  32'(randomData),  32'hA5);
        to_cyc(30);
        chk("c_valid_hold", 32'(randomValid), 32'd1);
        chk("c_data_hold",  32'(randomData),  32'hA5);
        to_cyc(31);
        randomReady = 1'b1;
        to_cyc(32);
        chk("c_valid_w2", 32'(randomValid), 32'd1);
        chk("c_data_w2",  32'(randomData),  32'h69);
        to_cyc(33);
        chk("c_w3_dropped", 32'(randomValid), 32'd0);
        enable = 1'b0;
        to_cyc(36);
`endif

        // Asynchronous reset in the middle of RUN with a word pending
        randomReady = 1'b0;
        start(E_STREAM, E_LEN);
        to_cyc(E_AT);
        chk("e_valid_pre", 32'(randomValid), 32'd1);
        chk("e_data_pre",  32'(randomData),  E_WORD);
        chk("e_roen_pre",  32'(roEnable),    32'd1);
        #1 rst = 1'b1;
        enable = 1'b0;
        #1 chk_all_zero("e_async");
        #1 rst = 1'b0;
        @(negedge clk);
        chk_all_zero("e_after");
        repeat (2) @(negedge clk);

        // Stuck input: repetition fault after exactly 32 raw bits of RUN
        randomReady = 1'b1;
        fill_bit    = 1'b0;
        start(64'h0, 0);
        to_cyc(37);
        chk("d_fail_pre", 32'(healthFail), 32'd0);
        chk("d_roen_pre", 32'(roEnable),   32'd1);
        to_cyc(38);
        chk("d_fail",  32'(healthFail),  32'd1);
        chk("d_roen",  32'(roEnable),    32'd0);
        chk("d_valid", 32'(randomValid), 32'd0);
        enable = 1'b0;
        to_cyc(40);
        enable = 1'b1;
        to_cyc(43);
        chk("d_fail_held",  32'(healthFail),  32'd1);
        chk("d_roen_held",  32'(roEnable),    32'd0);
        chk("d_valid_held", 32'(randomValid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
